// File: rtl/packet_sink.sv
// packet_sink: ejection-port sink that frames flits per virtual channel into
// packet descriptors and queues them in a first-word-fall-through FIFO.
// Optional feature: define PACKET_SINK_DEST_CHECK_EN to flag packets whose
// head destination (bits[3:0]*DIM + bits[7:4]) differs from ID (err 2).
module packet_sink #(
  parameter int ID         = 0,
  parameter int N          = 9,
  parameter int VC         = 4,
  parameter int DESC_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_out,
  input  logic        valid_out,
  output logic        ready_out,
  input  logic [1:0]  vc_sel,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [7:0]  desc_src,
  output logic [11:0] desc_msg,
  output logic [1:0]  desc_vc,
  output logic [7:0]  desc_len,
  output logic [1:0]  desc_err,
  output logic [15:0] pkt_count
);

  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  localparam int DIM = isqrt(N);
  localparam int AW  = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int VW  = (VC > 1) ? $clog2(VC) : 1;
  localparam logic [AW:0] FULL_COUNT = DESC_DEPTH[AW:0];

  typedef enum logic {S_IDLE, S_ACTIVE} vc_state_e;
  typedef enum logic [1:0] {FT_RSVD = 2'b00, FT_HEAD = 2'b01, FT_BODY = 2'b10, FT_TAIL = 2'b11} flit_e;
  typedef enum logic [1:0] {ERR_OK = 2'd0, ERR_FRAME = 2'd1, ERR_DEST = 2'd2, ERR_OVF = 2'd3} err_e;

  typedef struct packed {
    logic [7:0]  src;
    logic [11:0] msg;
    logic [1:0]  vc;
    logic [7:0]  len;
    err_e        err;
  } desc_t;

  // Per-VC framing state
  vc_state_e   state_q [VC];
  vc_state_e   state_d [VC];
  logic [7:0]  src_q   [VC];
  logic [7:0]  src_d   [VC];
  logic [11:0] msg_q   [VC];
  logic [11:0] msg_d   [VC];
  logic [7:0]  len_q   [VC];
  logic [7:0]  len_d   [VC];
  logic        ovf_q   [VC];
  logic        ovf_d   [VC];
`ifdef PACKET_SINK_DEST_CHECK_EN
  logic        dst_q   [VC];
  logic        dst_d   [VC];
`endif

  // Descriptor FIFO
  desc_t          mem_q [DESC_DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic [15:0]    pkt_count_q;

  flit_e          flit_type;
  logic [VW-1:0]  vi;
  logic           vc_ok;
  logic           flit_acc;
  logic           push;
  logic           pop;
  desc_t          push_desc;
  desc_t          frame_desc;
  desc_t          head_desc;
  err_e           tail_err;
  logic [7:0]     tail_len;
  logic           dest_mismatch;
  logic           unused_bits;

  assign flit_type     = flit_e'(data_out[31:30]);
  assign vi            = vc_sel[VW-1:0];
  assign vc_ok         = int'(vc_sel) < VC;
  assign ready_out     = (count_q != FULL_COUNT);
  assign flit_acc      = valid_out & ready_out;
  assign desc_valid    = (count_q != '0);
  assign pop           = desc_valid & desc_ready;
  assign dest_mismatch = (int'(data_out[3:0]) * DIM + int'(data_out[7:4])) != ID;

  // A stray flit is reported as a one-flit framing error carrying its own fields
  assign frame_desc = '{src: data_out[15:8], msg: data_out[27:16], vc: vc_sel,
                        len: 8'd1, err: ERR_FRAME};

`ifdef PACKET_SINK_DEST_CHECK_EN
  assign unused_bits = ^data_out[29:28];
`else
  assign unused_bits = ^{data_out[29:28], dest_mismatch};
`endif

  // Next-state of the selected VC's framer and the descriptor to push
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    src_d     = src_q;
    msg_d     = msg_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
`ifdef PACKET_SINK_DEST_CHECK_EN
    dst_d     = dst_q;
`endif
    push      = 1'b0;
    push_desc = frame_desc;
    tail_len  = (len_q[vi] == 8'hFF) ? 8'hFF : len_q[vi] + 8'd1;
    // Error priority: framing (handled by the caller paths) > overflow > destination
    tail_err  = ERR_OK;
    if (ovf_q[vi] || (len_q[vi] == 8'hFF)) begin
      tail_err = ERR_OVF;
    end
`ifdef PACKET_SINK_DEST_CHECK_EN
    else if (dst_q[vi]) begin
      tail_err = ERR_DEST;
    end
`endif

    if (flit_acc && vc_ok) begin
      case (flit_type)
        FT_HEAD: begin
          if (state_q[vi] == S_ACTIVE) begin
            push      = 1'b1;
            push_desc = '{src: src_q[vi], msg: msg_q[vi], vc: vc_sel,
                          len: len_q[vi], err: ERR_FRAME};
          end
          state_d[vi] = S_ACTIVE;
          src_d[vi]   = data_out[15:8];
          msg_d[vi]   = data_out[27:16];
          len_d[vi]   = 8'd1;
          ovf_d[vi]   = 1'b0;
`ifdef PACKET_SINK_DEST_CHECK_EN
          dst_d[vi]   = dest_mismatch;
`endif
        end
        FT_BODY: begin
          if (state_q[vi] == S_ACTIVE) begin
            if (len_q[vi] == 8'hFF) ovf_d[vi] = 1'b1;
            else                    len_d[vi] = len_q[vi] + 8'd1;
          end else begin
            push        = 1'b1;
            state_d[vi] = S_IDLE;
          end
        end
        FT_TAIL: begin
          push        = 1'b1;
          state_d[vi] = S_IDLE;
          if (state_q[vi] == S_ACTIVE) begin
            push_desc = '{src: src_q[vi], msg: msg_q[vi], vc: vc_sel,
                          len: tail_len, err: tail_err};
          end
        end
        default: begin
          push        = 1'b1;
          state_d[vi] = S_IDLE;
        end
      endcase
    end
  end

  // Per-VC framer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC; v++) begin
        state_q[v] <= S_IDLE;
        src_q[v]   <= '0;
        msg_q[v]   <= '0;
        len_q[v]   <= '0;
        ovf_q[v]   <= 1'b0;
`ifdef PACKET_SINK_DEST_CHECK_EN
        dst_q[v]   <= 1'b0;
`endif
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q <= state_d;
      src_q   <= src_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
`ifdef PACKET_SINK_DEST_CHECK_EN
      dst_q   <= dst_d;
`endif
    end
  end

  // Descriptor FIFO storage, pointers, occupancy and the pushed-packet counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: storage is reset because the fall-through desc fields must read zero in reset.
      for (int i = 0; i < DESC_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_desc;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        pkt_count_q     <= pkt_count_q + 16'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_desc = mem_q[rd_ptr_q];
  assign desc_src  = head_desc.src;
  assign desc_msg  = head_desc.msg;
  assign desc_vc   = head_desc.vc;
  assign desc_len  = head_desc.len;
  assign desc_err  = head_desc.err;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_packet_sink.sv
// tb_packet_sink: directed and randomized stimulus for packet_sink, checked
// against a packet-level reference model (flit counts and a descriptor queue).
module tb_packet_sink;

  localparam int ID    = 4;
  localparam int DIM   = 3;
  localparam int VC    = 4;
  localparam int DEPTH = 4;
  localparam logic [7:0] GOOD_DST = 8'h11;  // 1*3 + 1 == ID
`ifdef PACKET_SINK_DEST_CHECK_EN
  localparam logic [1:0] DEST_ERR = 2'd2;
`else
  localparam logic [1:0] DEST_ERR = 2'd0;
`endif

  typedef struct packed {
    logic [7:0]  src;
    logic [11:0] msg;
    logic [1:0]  vc;
    logic [7:0]  len;
    logic [1:0]  err;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_out = '0;
  logic        valid_out = 1'b0;
  logic        ready_out;
  logic [1:0]  vc_sel = '0;
  logic        desc_valid;
  logic        desc_ready = 1'b0;
  logic [7:0]  desc_src;
  logic [11:0] desc_msg;
  logic [1:0]  desc_vc;
  logic [7:0]  desc_len;
  logic [1:0]  desc_err;
  logic [15:0] pkt_count;
  logic [31:0] dut_desc;
  bit          rand_mode = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  packet_sink #(.ID(ID), .N(9), .VC(VC), .DESC_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .vc_sel(vc_sel), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_src(desc_src), .desc_msg(desc_msg),
    .desc_vc(desc_vc), .desc_len(desc_len), .desc_err(desc_err),
    .pkt_count(pkt_count)
  );

  assign dut_desc = {desc_src, desc_msg, desc_vc, desc_len, desc_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  desc_t       exp_q[$];
  logic [15:0] exp_cnt;
  bit          open_m [VC];
  logic [31:0] head_m [VC];
  int          nfl_m  [VC];

  function automatic bit dest_bad(input logic [31:0] w);
`ifdef PACKET_SINK_DEST_CHECK_EN
    return (int'(w[3:0]) * DIM + int'(w[7:4])) != ID;
`else
    return 1'b0;
`endif
  endfunction

  function automatic desc_t mkdesc(input logic [31:0] w, input logic [1:0] vc,
                                   input int n, input logic [1:0] err);
    desc_t d;
    d.src = w[15:8];
    d.msg = w[27:16];
    d.vc  = vc;
    d.len = (n > 255) ? 8'hFF : n[7:0];
    d.err = err;
    return d;
  endfunction

  task automatic emit(input desc_t d);
    exp_q.push_back(d);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic model_flit(input logic [1:0] vc, input logic [31:0] w);
    logic [1:0] err;
    case (w[31:30])
      2'b01: begin
        if (open_m[vc]) emit(mkdesc(head_m[vc], vc, nfl_m[vc], 2'd1));
        open_m[vc] = 1'b1;
        head_m[vc] = w;
        nfl_m[vc]  = 1;
      end
      2'b10: begin
        if (open_m[vc]) nfl_m[vc]++;
        else emit(mkdesc(w, vc, 1, 2'd1));
      end
      2'b11: begin
        if (open_m[vc]) begin
          nfl_m[vc]++;
          if (nfl_m[vc] > 255)         err = 2'd3;
          else if (dest_bad(head_m[vc])) err = 2'd2;
          else                          err = 2'd0;
          emit(mkdesc(head_m[vc], vc, nfl_m[vc], err));
        end else begin
          emit(mkdesc(w, vc, 1, 2'd1));
        end
        open_m[vc] = 1'b0;
      end
      default: begin
        emit(mkdesc(w, vc, 1, 2'd1));
        open_m[vc] = 1'b0;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst) begin : model_step
    int sz;
    if (!rst) begin
      exp_q.delete();
      exp_cnt = '0;
      for (int v = 0; v < VC; v++) begin
        open_m[v] = 1'b0;
        nfl_m[v]  = 0;
      end
    end else begin
      sz = exp_q.size();
      if (valid_out && sz < DEPTH) model_flit(vc_sel, data_out);
      if (sz > 0 && desc_ready) void'(exp_q.pop_front());
    end
  end

  // Compare DUT outputs with the model away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_valid", 32'(desc_valid), 32'd0);
      check("rst_ready", 32'(ready_out), 32'd1);
      check("rst_count", 32'(pkt_count), 32'd0);
      check("rst_desc", dut_desc, 32'd0);
    end else begin
      check("desc_valid", 32'(desc_valid), 32'(exp_q.size() > 0));
      check("ready_out", 32'(ready_out), 32'(exp_q.size() < DEPTH));
      check("pkt_count", 32'(pkt_count), 32'(exp_cnt));
      if (exp_q.size() > 0) check("desc_fields", dut_desc, exp_q[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk(input logic [1:0] t, input logic [7:0] src,
                                     input logic [11:0] msg, input logic [7:0] dst);
    return {t, 2'b00, msg, src, dst};
  endfunction

  task automatic send(input logic [1:0] vc, input logic [31:0] w);
    int waited;
    bit got;
    waited    = 0;
    valid_out = 1'b1;
    vc_sel    = vc;
    data_out  = w;
    while (1) begin
      @(negedge clk);
      got = ready_out;
      @(posedge clk);
      #1;
      if (rand_mode) desc_ready = ($urandom_range(0, 9) < 7);
      if (got) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 32'(got), 32'd1);
        break;
      end
    end
    valid_out = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_out = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_mode) desc_ready = ($urandom_range(0, 9) < 7);
    end
  endtask

  task automatic pop1();
    desc_ready = 1'b1;
    @(posedge clk);
    #1;
    desc_ready = 1'b0;
  endtask

  task automatic send_long(input logic [1:0] vc, input logic [7:0] src, input int bodies);
    send(vc, mk(2'b01, src, 12'h0AB, GOOD_DST));
    for (int i = 0; i < bodies; i++) send(vc, mk(2'b10, 8'hEE, 12'h0, 8'h0));
    send(vc, mk(2'b11, 8'hEF, 12'h0, 8'h0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic four-flit packet on VC 0
    send(0, mk(2'b01, 8'h12, 12'd5, GOOD_DST));
    send(0, mk(2'b10, 8'hAA, 12'h0, 8'h0));
    send(0, mk(2'b10, 8'hAA, 12'h0, 8'h0));
    send(0, mk(2'b11, 8'hAA, 12'h0, 8'h0));
    check("basic_valid", 32'(desc_valid), 32'd1);
    check("basic_desc", dut_desc, {8'h12, 12'd5, 2'd0, 8'd4, 2'd0});
    check("basic_count", 32'(pkt_count), 32'd1);
    pop1();

    // Orphan tail, then orphan body proves VC 1 stayed idle
    send(1, mk(2'b11, 8'h34, 12'd7, 8'h0));
    check("orphan_tail", dut_desc, {8'h34, 12'd7, 2'd1, 8'd1, 2'd1});
    pop1();
    send(1, mk(2'b10, 8'h35, 12'd8, 8'h0));
    check("orphan_body", dut_desc, {8'h35, 12'd8, 2'd1, 8'd1, 2'd1});
    pop1();

    // Head interrupts an open packet on VC 2
    send(2, mk(2'b01, 8'h56, 12'd9, GOOD_DST));
    send(2, mk(2'b10, 8'h00, 12'h0, 8'h0));
    send(2, mk(2'b01, 8'h57, 12'd10, GOOD_DST));
    send(2, mk(2'b11, 8'h00, 12'h0, 8'h0));
    check("abort_desc", dut_desc, {8'h56, 12'd9, 2'd2, 8'd2, 2'd1});
    pop1();
    check("restart_desc", dut_desc, {8'h57, 12'd10, 2'd2, 8'd2, 2'd0});
    pop1();
    check("abort_count", 32'(pkt_count), 32'd5);

    // VC 0 and VC 3 interleaved cycle by cycle
    send(0, mk(2'b01, 8'h60, 12'd1, GOOD_DST));
    send(3, mk(2'b01, 8'h63, 12'd3, GOOD_DST));
    send(0, mk(2'b10, 8'h00, 12'h0, 8'h0));
    send(3, mk(2'b10, 8'h00, 12'h0, 8'h0));
    send(0, mk(2'b11, 8'h00, 12'h0, 8'h0));
    send(3, mk(2'b11, 8'h00, 12'h0, 8'h0));
    check("ilv_vc0", dut_desc, {8'h60, 12'd1, 2'd0, 8'd3, 2'd0});
    pop1();
    check("ilv_vc3", dut_desc, {8'h63, 12'd3, 2'd3, 8'd3, 2'd0});
    pop1();

    // Head addressed to node 0 while this port is node 4
    send(1, mk(2'b01, 8'h41, 12'h041, 8'h00));
    send(1, mk(2'b11, 8'h00, 12'h0, 8'h0));
    check("dest_desc", dut_desc, {8'h41, 12'h041, 2'd1, 8'd2, DEST_ERR});
    pop1();

    // Fill the FIFO, then one pop reopens the input
    for (int i = 0; i < DEPTH; i++) begin
      send(2'(i), mk(2'b01, 8'(8'hB0 + i), 12'(i), GOOD_DST));
      send(2'(i), mk(2'b11, 8'h00, 12'h0, 8'h0));
    end
    check("full_ready", 32'(ready_out), 32'd0);
    pop1();
    check("pop_ready", 32'(ready_out), 32'd1);
    desc_ready = 1'b1;
    idle(6);
    desc_ready = 1'b0;

    // Length boundaries: 255 flits exactly, then 257 flits overflowing
    send_long(0, 8'hC5, 253);
    check("len255_desc", dut_desc, {8'hC5, 12'h0AB, 2'd0, 8'd255, 2'd0});
    pop1();
    send_long(2, 8'hC7, 255);
    check("len257_desc", dut_desc, {8'hC7, 12'h0AB, 2'd2, 8'd255, 2'd3});
    pop1();

    // Reserved flit inside a packet closes it
    send(3, mk(2'b01, 8'h80, 12'h080, GOOD_DST));
    send(3, mk(2'b00, 8'h81, 12'h081, 8'h0));
    check("rsvd_desc", dut_desc, {8'h81, 12'h081, 2'd3, 8'd1, 2'd1});
    pop1();
    send(3, mk(2'b11, 8'h82, 12'h082, 8'h0));
    check("rsvd_idle", dut_desc, {8'h82, 12'h082, 2'd3, 8'd1, 2'd1});
    pop1();

    // Reset with a queued descriptor and an open packet discards both
    send(0, mk(2'b01, 8'h90, 12'h090, GOOD_DST));
    send(0, mk(2'b11, 8'h00, 12'h0, 8'h0));
    send(1, mk(2'b01, 8'h92, 12'h092, GOOD_DST));
    send(1, mk(2'b10, 8'h00, 12'h0, 8'h0));
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    check("post_rst_valid", 32'(desc_valid), 32'd0);
    check("post_rst_count", 32'(pkt_count), 32'd0);
    send(1, mk(2'b11, 8'h91, 12'h091, 8'h0));
    check("post_rst_tail", dut_desc, {8'h91, 12'h091, 2'd1, 8'd1, 2'd1});
    pop1();

    // Randomized traffic with back-pressure and one mid-stream reset
    rand_mode = 1'b1;
    for (int it = 0; it < 1200; it++) begin
      int r;
      logic [1:0] t;
      logic [7:0] dst;
      if (it == 600) begin
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
      end
      r = $urandom_range(0, 99);
      if (r < 25)      t = 2'b01;
      else if (r < 65) t = 2'b10;
      else if (r < 90) t = 2'b11;
      else             t = 2'b00;
      dst = ($urandom_range(0, 3) != 0) ? GOOD_DST : 8'($urandom);
      if ($urandom_range(0, 9) == 0) idle(1);
      send(2'($urandom), {t, 2'($urandom), 12'($urandom), 8'($urandom), dst});
    end
    rand_mode  = 1'b0;
    desc_ready = 1'b1;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
